// File: rtl/guangsai_dac_pkg.sv
// Shared types and default sizing for the laser-control DAC write channels.
package guangsai_dac_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      SHIFT,
      LDAC
   } dac_state_e;

   localparam int DAC_DATA_WIDTH = 16;
   localparam int DAC_CLK_DIV    = 4;
   localparam int DAC_LDAC_PULSE = 2;

endpackage

// File: rtl/dac_sck_divider.sv
// Phase counter for the local SCK: one-cycle tick every CLK_DIV clocks.
module dac_sck_divider #(
   parameter int CLK_DIV = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic tick
);

   localparam int CW = $clog2(CLK_DIV + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      tick  = 1'b0;
      if (clear || !run) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         tick  = 1'b1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/dac_spi_writer.sv
// Single-channel SPI write engine: one DAC code per handshake, MSB first,
// followed by an LDAC latch pulse.
module dac_spi_writer
   import guangsai_dac_pkg::*;
#(
   parameter int DATA_WIDTH = DAC_DATA_WIDTH,
   parameter int CLK_DIV    = DAC_CLK_DIV,
   parameter int LDAC_PULSE = DAC_LDAC_PULSE
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_bits,
   output logic                  dac_sck,
   output logic                  dac_cs,
   output logic                  dac_sdi,
   output logic                  dac_ldac,
   output logic                  busy,
   output logic                  done
);

   localparam int BW = $clog2(DATA_WIDTH + 1);
   localparam int LW = $clog2(LDAC_PULSE + 1);
   localparam logic [BW-1:0] BIT_END   = BW'(DATA_WIDTH);
   localparam logic [LW-1:0] LDAC_LAST = LW'(LDAC_PULSE - 1);

   dac_state_e            state_q, state_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic [LW-1:0]         lcnt_q, lcnt_d;
   logic                  sck_q, sck_d;
   logic                  cs_q, cs_d;
   logic                  sdi_q, sdi_d;
   logic                  ldac_q, ldac_d;
   logic                  done_q, done_d;

   logic accept;
   logic run;
   logic tick;

   assign in_ready = en && (state_q == IDLE);
   assign accept   = in_valid && in_ready;
   assign run      = (state_q == SETUP) || (state_q == SHIFT);

   dac_sck_divider #(
      .CLK_DIV(CLK_DIV)
   ) u_div (
      .clock(clock),
      .reset(reset),
      .clear(accept),
      .run  (run),
      .tick (tick)
   );

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      bit_d   = bit_q;
      lcnt_d  = lcnt_q;
      sck_d   = sck_q;
      cs_d    = cs_q;
      sdi_d   = sdi_q;
      ldac_d  = ldac_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = SETUP;
               shreg_d = in_bits;
               bit_d   = '0;
               cs_d    = 1'b0;
               sdi_d   = in_bits[DATA_WIDTH-1];
            end
         end
         SETUP: begin
            if (tick) begin
               state_d = SHIFT;
               sck_d   = 1'b1;
            end
         end
         SHIFT: begin
            if (tick) begin
               if (sck_q) begin
                  // Zeros shift in, so SDI falls to 0 after the last bit.
                  sck_d   = 1'b0;
                  shreg_d = shreg_q << 1;
                  sdi_d   = shreg_q[DATA_WIDTH-2];
                  bit_d   = bit_q + 1'b1;
               end else if (bit_q == BIT_END) begin
                  state_d = LDAC;
                  cs_d    = 1'b1;
                  ldac_d  = 1'b0;
                  lcnt_d  = '0;
               end else begin
                  sck_d = 1'b1;
               end
            end
         end
         LDAC: begin
            if (lcnt_q == LDAC_LAST) begin
               state_d = IDLE;
               ldac_d  = 1'b1;
               done_d  = 1'b1;
            end else begin
               lcnt_d = lcnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         shreg_q <= '0;
         bit_q   <= '0;
         lcnt_q  <= '0;
         sck_q   <= 1'b0;
         cs_q    <= 1'b1;
         sdi_q   <= 1'b0;
         ldac_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         bit_q   <= bit_d;
         lcnt_q  <= lcnt_d;
         sck_q   <= sck_d;
         cs_q    <= cs_d;
         sdi_q   <= sdi_d;
         ldac_q  <= ldac_d;
         done_q  <= done_d;
      end
   end

   assign dac_sck  = sck_q;
   assign dac_cs   = cs_q;
   assign dac_sdi  = sdi_q;
   assign dac_ldac = ldac_q;
   assign busy     = (state_q != IDLE);
   assign done     = done_q;

endmodule
